// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: feeds operands LSB-first through a 1-bit add/sub/and/or
// slice with a registered carry flop, and returns a parallel result with carry and zero flags.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             s1_i,
    input  logic             s0_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] r_o,
    output logic             c_o,
    output logic             z_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             z_q, z_d;

    logic bit_a, bit_b, sum_bit, carry_out, res_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    // Subtraction is A + ~B + 1: B is inverted here and the carry flop starts at 1.
    always_comb begin
        bit_a     = a_sh_q[0];
        bit_b     = b_sh_q[0] ^ (op_q == OP_SUB);
        sum_bit   = bit_a ^ bit_b ^ cy_q;
        carry_out = (bit_a & bit_b) | (bit_a & cy_q) | (bit_b & cy_q);
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        op_d    = op_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        c_d     = c_q;
        z_d     = z_q;
        res_bit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    op_d    = {s1_i, s0_i};
                    cy_d    = ({s1_i, s0_i} == OP_SUB);
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_bit = sum_bit;
                        cy_d    = carry_out;
                    end
                    OP_AND:  res_bit = a_sh_q[0] & b_sh_q[0];
                    default: res_bit = a_sh_q[0] | b_sh_q[0];
                endcase
                res_d  = {res_bit, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                // Final bit: publish the result so it is valid in the done cycle.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    r_d     = res_d;
                    z_d     = (res_d == '0);
                    case (op_q)
                        OP_ADD:  c_d = cy_d;
                        OP_SUB:  c_d = ~cy_d;
                        default: c_d = 1'b0;
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign r_o    = r_q;
    assign c_o    = c_q;
    assign z_o    = z_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: arithmetic reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         s1 = 1'b0;
    logic         s0 = 1'b0;
    logic         busy, done, c, z;
    logic [W-1:0] r;

    int checks = 0;
    int failures = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .s1_i(s1), .s0_i(s0), .busy_o(busy), .done_o(done),
        .r_o(r), .c_o(c), .z_o(z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {carry, result} from plain arithmetic on the operands.
    function automatic logic [W:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [1:0] op);
        logic [W:0] s;
        case (op)
            2'b00:   s = {1'b0, x} + {1'b0, y};
            2'b01:   s = {(x < y), x - y};
            2'b10:   s = {1'b0, x & y};
            default: s = {1'b0, x | y};
        endcase
        return s;
    endfunction

    // Model: an accepted request keeps the block busy for W+1 cycles, the last being done.
    int           m_rem = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_r = '0;
    logic         m_c = 1'b0;
    logic         m_z = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0;
            m_r   = '0;
            m_c   = 1'b0;
            m_z   = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem  = W + 1;
                m_pend = calc(a, b, {s1, s0});
            end
        end else begin
            m_rem--;
            if (m_rem == 1) begin
                m_r = m_pend[W-1:0];
                m_c = m_pend[W];
                m_z = (m_pend[W-1:0] == '0);
            end
        end
    end

    int   cyc = 0;
    logic phase6 = 1'b0;
    int   p6_dones = 0;
    int   last_done = 0;

    always @(negedge clk) begin
        cyc++;
        chk("busy", busy, (m_rem != 0));
        chk("done", done, (m_rem == 1));
        chk("R", r, m_r);
        chk("C", c, m_c);
        chk("Z", z, m_z);
        if (phase6 && done) begin
            if (p6_dones > 0) chk("done_spacing", cyc - last_done, 10);
            last_done = cyc;
            p6_dones++;
        end
    end

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] op,
                         input logic [W-1:0] er, input logic ec, input logic ez);
        int bc, dn;
        a = xa; b = xb; {s1, s0} = op; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bc = 0; dn = 0;
        for (int n = 1; n <= 12; n++) begin
            if (busy) bc++;
            if (done && dn == 0) dn = n;
            if (n < 12) @(negedge clk);
        end
        chk("lat_done", dn, 9);
        chk("busy_cycles", bc, 9);
        chk("lit_R", r, er);
        chk("lit_C", c, ec);
        chk("lit_Z", z, ez);
    endtask

    initial begin
        int dn, dcount;
        logic [W-1:0] ta [6] = '{8'h80, 8'h03, 8'hAA, 8'h50, 8'h7F, 8'h10};
        logic [W-1:0] tb [6] = '{8'h80, 8'h04, 8'h0F, 8'h05, 8'h01, 8'h10};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_R", r, 0);
        chk("rst_CZ", {c, z}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1);
        do_op(8'h05, 8'h07, 2'b01, 8'hFE, 1'b1, 1'b0);
        do_op(8'h07, 8'h05, 2'b01, 8'h02, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0);
        do_op(8'hF0, 8'h3C, 2'b11, 8'hFC, 1'b0, 1'b0);

        // Start and operand changes during RUN must not disturb the operation in flight.
        a = 8'h10; b = 8'h20; {s1, s0} = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dn = 0; dcount = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; {s1, s0} = 2'b11; end
            if (n == 4) start = 1'b0;
            if (done) begin dcount++; if (dn == 0) dn = n; end
            if (n < 12) @(negedge clk);
        end
        chk("midrun_dones", dcount, 1);
        chk("midrun_lat", dn, 9);
        chk("midrun_R", r, 8'h30);
        repeat (5) @(negedge clk);
        chk("hold_R", r, 8'h30);

        // Reset during RUN aborts without a done pulse.
        a = 8'h33; b = 8'h11; {s1, s0} = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_R", r, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        do_op(8'h01, 8'h01, 2'b00, 8'h02, 1'b0, 1'b0);

        // Back-to-back operations with start held high.
        phase6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = ta[i]; b = tb[i]; {s1, s0} = 2'(i % 4); start = 1'b1;
            @(posedge clk);
            repeat (9) @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        phase6 = 1'b0;
        chk("b2b_dones", p6_dones, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
